// File: rtl/avmm_arb_pkg.sv
// Shared definitions for the two-master Avalon-MM GPIO arbiter: FSM states, response codes, tie-break helper.
package avmm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_ERR    = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Returns 1 when m1 should take the next grant; on a tie the master not served last wins.
    function automatic logic rr_pick_m1(input logic req0, input logic req1, input logic last_m1);
        return req1 && (!req0 || !last_m1);
    endfunction

endpackage

// File: rtl/avmm_arb_watchdog.sv
// Slave-stall watchdog: counts stalled grant cycles, flags expiry on the TIMEOUT-th one.
// Latency: expired is combinational in the cycle the count would reach TIMEOUT.
// Backpressure: none; it only observes the stall qualifier.
module avmm_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Asserted while the current stalled cycle is the TIMEOUT-th in a row.
    assign expired = enable && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/avmm_gpio_arbiter.sv
// Round-robin arbiter sharing one GPIO Avalon-MM slave between the CPU (m0, lockable) and an I2C bridge (m1).
// Latency: one grant cycle then one slave cycle per transfer (2 cycles min); stalls abort to SLVERR after TIMEOUT.
// Backpressure: slave waitrequest passes through to the granted master; the other master is held in waitrequest.
module avmm_gpio_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 255,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    input  logic              m0_lock,
    output logic [31:0]       m0_readdata,
    output logic              m0_waitrequest,
    output logic [1:0]        m0_response,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic [31:0]       m1_readdata,
    output logic              m1_waitrequest,
    output logic [1:0]        m1_response,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [31:0]       s_writedata,
    input  logic [31:0]       s_readdata,
    input  logic              s_waitrequest
);
    localparam int LCK_W = $clog2(LOCK_MAX + 1);
    localparam logic [LCK_W-1:0] LCK_ONE = LCK_W'(1);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic             err_mst_q, err_mst_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;

    logic req0, req1;
    logic in_grant, gnt_m1;
    logic g_read, g_write, g_req, g_bad;
    logic complete, stall, lock_hold;
    logic wd_clear, wd_expired;

    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        in_grant  = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
        gnt_m1    = (state_q == ST_GRANT1);
        g_read    = gnt_m1 ? m1_read  : m0_read;
        g_write   = gnt_m1 ? m1_write : m0_write;
        g_req     = g_read | g_write;
        g_bad     = g_read & g_write;
        complete  = in_grant && g_req && !g_bad && !s_waitrequest;
        stall     = in_grant && g_req && !g_bad && s_waitrequest;
        lock_hold = (state_q == ST_GRANT0) && m0_lock && ((int'(lock_cnt_q) + 1) < LOCK_MAX);
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        err_mst_d  = err_mst_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    last_d  = rr_pick_m1(req0, req1, last_q);
                    state_d = last_d ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                // A dropped request is a master protocol error: abandon silently.
                if (!g_req) begin
                    state_d = ST_IDLE;
                end else if (g_bad || wd_expired) begin
                    state_d   = ST_ERR;
                    err_mst_d = gnt_m1;
                end else if (complete) begin
                    if (lock_hold) begin
                        lock_cnt_d = lock_cnt_q + LCK_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_IDLE) begin
            lock_cnt_d = '0;
        end
    end

    assign wd_clear = complete || (state_d != state_q);

    avmm_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable        (stall),
        .clear         (wd_clear),
        .expired       (wd_expired)
    );

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_readdata    = '0;
        m0_waitrequest = 1'b1;
        m0_response    = RESP_OKAY;
        m1_readdata    = '0;
        m1_waitrequest = 1'b1;
        m1_response    = RESP_OKAY;
        if (in_grant) begin
            s_address   = gnt_m1 ? m1_address   : m0_address;
            s_writedata = gnt_m1 ? m1_writedata : m0_writedata;
            s_read      = g_read  & ~g_bad;
            s_write     = g_write & ~g_bad;
        end
        // An illegal read+write keeps the master waiting until the SLVERR cycle.
        case (state_q)
            ST_GRANT0: begin
                m0_waitrequest = g_bad | s_waitrequest;
                m0_readdata    = s_readdata;
            end
            ST_GRANT1: begin
                m1_waitrequest = g_bad | s_waitrequest;
                m1_readdata    = s_readdata;
            end
            ST_ERR: begin
                if (err_mst_q) begin
                    m1_waitrequest = 1'b0;
                    m1_response    = RESP_SLVERR;
                end else begin
                    m0_waitrequest = 1'b0;
                    m0_response    = RESP_SLVERR;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            err_mst_q  <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            err_mst_q  <= err_mst_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: tb/tb_avmm_gpio_arbiter.sv
// Directed bench for avmm_gpio_arbiter: single read, round-robin, lock, timeout, illegal strobe, mid-transfer reset.
module tb_avmm_gpio_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [7:0]  m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [1:0]  m0_response, m1_response;
    logic        s_read, s_write;

    int          checks = 0;
    int          errors = 0;
    int          ng;
    int          stalls;
    logic [31:0] got [0:7];

    always #5 clk_clk = ~clk_clk;

    avmm_gpio_arbiter #(.ADDR_W(8), .TIMEOUT(255), .LOCK_MAX(4)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_lock        (m0_lock),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m0_response    (m0_response),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .m1_response    (m1_response),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest)
    );

    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Both masters issue writes until their quota is served; slave never stalls.
    task automatic run_writes(input int t0, input int t1, input logic lk,
                              input logic [31:0] b0, input logic [31:0] b1);
        int n0 = 0;
        int n1 = 0;
        ng = 0;
        for (int c = 0; c < 40 && (n0 < t0 || n1 < t1); c++) begin
            cyc();
            m0_write     = (n0 < t0);
            m0_lock      = lk && (n0 < t0);
            m0_writedata = b0 + 32'(n0);
            m0_address   = 8'h10;
            m1_write     = (n1 < t1);
            m1_writedata = b1 + 32'(n1);
            m1_address   = 8'h20;
            settle();
            if (s_write && !s_waitrequest) begin
                if (ng < 8) got[ng] = s_writedata;
                ng++;
            end
            if (m0_write && !m0_waitrequest) n0++;
            if (m1_write && !m1_waitrequest) n1++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset_reset_n = 1'b0;
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_lock = 0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
        s_readdata = '0; s_waitrequest = 1'b0;
        cyc();
        cyc();
        settle();
        chk("rst_s_read",   32'(s_read),         32'd0);
        chk("rst_s_write",  32'(s_write),        32'd0);
        chk("rst_m0_wait",  32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait",  32'(m1_waitrequest), 32'd1);
        chk("rst_m0_resp",  32'(m0_response),    32'd0);
        chk("rst_m1_rdata", m1_readdata,         32'd0);

        // Single zero-wait read by m0
        cyc();
        reset_reset_n = 1'b1;
        m0_address = 8'h04; m0_read = 1; s_readdata = 32'hDEADBEEF; s_waitrequest = 0;
        settle();
        chk("rd_c1_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("rd_c1_s_read",  32'(s_read),         32'd0);
        cyc();
        settle();
        chk("rd_c2_s_read",  32'(s_read),         32'd1);
        chk("rd_c2_s_addr",  32'(s_address),      32'h04);
        chk("rd_c2_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("rd_c2_m0_data", m0_readdata,         32'hDEADBEEF);
        chk("rd_c2_m0_resp", 32'(m0_response),    32'd0);
        chk("rd_c2_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rd_c2_m1_data", m1_readdata,         32'd0);
        cyc();
        m0_read = 0;
        settle();
        chk("rd_c3_idle_s_read", 32'(s_read),         32'd0);
        chk("rd_c3_idle_m0_wait", 32'(m0_waitrequest), 32'd1);

        // Reset restores last-grant=m1, so the first tie goes to m0
        cyc();
        reset_reset_n = 1'b0;
        cyc();
        reset_reset_n = 1'b1;
        run_writes(3, 3, 1'b0, 32'hA000_0000, 32'hB000_0000);
        chk("rr_count", 32'(ng), 32'd6);
        chk("rr_g0", got[0], 32'hA000_0000);
        chk("rr_g1", got[1], 32'hB000_0000);
        chk("rr_g2", got[2], 32'hA000_0001);
        chk("rr_g3", got[3], 32'hB000_0001);
        chk("rr_g4", got[4], 32'hA000_0002);
        chk("rr_g5", got[5], 32'hB000_0002);
        cyc();
        m0_write = 0; m1_write = 0;

        // Locked m0 burst: 4 locked grants, then m1, then m0 again
        run_writes(6, 1, 1'b1, 32'hC000_0000, 32'hD000_0000);
        chk("lk_count", 32'(ng), 32'd7);
        chk("lk_g0", got[0], 32'hC000_0000);
        chk("lk_g1", got[1], 32'hC000_0001);
        chk("lk_g2", got[2], 32'hC000_0002);
        chk("lk_g3", got[3], 32'hC000_0003);
        chk("lk_g4", got[4], 32'hD000_0000);
        chk("lk_g5", got[5], 32'hC000_0004);
        chk("lk_g6", got[6], 32'hC000_0005);
        // Still held in GRANT0 by the lock; dropping the request abandons it silently
        cyc();
        m0_write = 0; m0_lock = 0;
        settle();
        chk("drop_s_write", 32'(s_write),     32'd0);
        chk("drop_m0_resp", 32'(m0_response), 32'd0);
        cyc();
        settle();
        chk("drop_idle_m0_wait", 32'(m0_waitrequest), 32'd1);

        // m1 read against a slave that never releases waitrequest
        cyc();
        m1_address = 8'h30; m1_read = 1; s_waitrequest = 1; s_readdata = 32'h1234_5678;
        settle();
        stalls = 0;
        for (int k = 0; k < 255; k++) begin
            cyc();
            settle();
            if (s_read && m1_waitrequest && (m1_response == 2'b00)) stalls++;
        end
        chk("to_stall_cycles", 32'(stalls), 32'd255);
        cyc();
        settle();
        chk("to_err_s_read",  32'(s_read),         32'd0);
        chk("to_err_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("to_err_m1_resp", 32'(m1_response),    32'd2);
        chk("to_err_m1_data", m1_readdata,         32'd0);
        chk("to_err_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("to_err_m0_resp", 32'(m0_response),    32'd0);
        cyc();
        m1_read = 0; s_waitrequest = 0;
        settle();
        chk("to_idle_m1_resp", 32'(m1_response),    32'd0);
        chk("to_idle_m1_wait", 32'(m1_waitrequest), 32'd1);

        // m0 with read and write both high
        cyc();
        m0_read = 1; m0_write = 1; m0_address = 8'h08;
        settle();
        cyc();
        settle();
        chk("rw_g_strobes", {30'd0, s_read, s_write}, 32'd0);
        chk("rw_g_m0_wait", 32'(m0_waitrequest),      32'd1);
        cyc();
        settle();
        chk("rw_err_strobes", {30'd0, s_read, s_write}, 32'd0);
        chk("rw_err_m0_resp", 32'(m0_response),         32'd2);
        chk("rw_err_m0_wait", 32'(m0_waitrequest),      32'd0);
        cyc();
        m0_read = 0; m0_write = 0;

        // Reset during the 3rd stall cycle of an m1 write
        cyc();
        m1_write = 1; m1_address = 8'h40; m1_writedata = 32'h5555_AAAA; s_waitrequest = 1;
        cyc();
        cyc();
        cyc();
        settle();
        chk("rs_stall3_s_write", 32'(s_write), 32'd1);
        reset_reset_n = 1'b0;
        cyc();
        reset_reset_n = 1'b1;
        m0_write = 1; m0_address = 8'h44; m0_writedata = 32'h0BAD_F00D; s_waitrequest = 0;
        settle();
        chk("rs_after_s_write", 32'(s_write),        32'd0);
        chk("rs_after_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rs_after_m1_resp", 32'(m1_response),    32'd0);
        cyc();
        settle();
        chk("rs_tie_s_addr",  32'(s_address),      32'h44);
        chk("rs_tie_s_wdata", s_writedata,         32'h0BAD_F00D);
        chk("rs_tie_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("rs_tie_m1_wait", 32'(m1_waitrequest), 32'd1);
        cyc();
        m0_write = 0; m1_write = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avmm_gpio_arbiter.md
AVMM_GPIO_ARBITER -- requirements
Module: avmm_gpio_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the word address width of all address ports.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum slave-stall cycles before abort.
REQ-003 The block SHALL have parameter LOCK_MAX, default 4, giving the maximum back-to-back locked grants.
REQ-004 The block SHALL have port clk_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset_reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have ports m0_address (in, ADDR_W), m0_read (in, 1), m0_write (in, 1), m0_writedata (in, 32), m0_lock (in, 1): the CPU data master request.
REQ-007 The block SHALL have ports m0_readdata (out, 32), m0_waitrequest (out, 1), m0_response (out, 2): the CPU data master reply.
REQ-008 The block SHALL have ports m1_address (in, ADDR_W), m1_read (in, 1), m1_write (in, 1), m1_writedata (in, 32): the I2C bridge master request; m1 has no lock input.
REQ-009 The block SHALL have ports m1_readdata (out, 32), m1_waitrequest (out, 1), m1_response (out, 2): the I2C bridge master reply.
REQ-010 The block SHALL have ports s_address (out, ADDR_W), s_read (out, 1), s_write (out, 1), s_writedata (out, 32): the shared GPIO slave request.
REQ-011 The block SHALL have ports s_readdata (in, 32) and s_waitrequest (in, 1): the shared GPIO slave reply.

Function
REQ-012 The arbiter SHALL use states IDLE, GRANT0, GRANT1 and ERR.
REQ-013 In IDLE it SHALL drive s_read=s_write=0 and m0_waitrequest=m1_waitrequest=1.
REQ-014 A master SHALL be requesting when its read or write is high.
REQ-015 From IDLE, a single requester SHALL be granted in the next cycle.
REQ-016 When both request in IDLE, the master not granted last SHALL win (round-robin).
REQ-017 After reset, the last-grant record SHALL be m1, so m0 wins the first tie.
REQ-018 In GRANTn, the slave outputs SHALL combinationally mirror master n's address, read, write and writedata.
REQ-019 In GRANTn, the other master's waitrequest SHALL be 1.
REQ-020 In GRANTn, mn_waitrequest SHALL equal s_waitrequest, and mn_readdata SHALL equal s_readdata.
REQ-021 The transfer SHALL complete in the first GRANTn cycle with s_waitrequest=0, with mn_response=00.
REQ-022 Minimum latency SHALL be 2 cycles from request to completion: grant cycle plus one slave cycle.
REQ-023 After completion, the arbiter SHALL return to IDLE.
REQ-024 Exception: if the grant is GRANT0, m0_lock=1 at completion, and fewer than LOCK_MAX consecutive locked grants have been made, the arbiter SHALL remain in GRANT0.
REQ-025 The locked-grant counter SHALL increment on each locked completion and clear on any return to IDLE.
REQ-026 When the locked-grant counter reaches LOCK_MAX, the arbiter SHALL return to IDLE even if m0_lock=1.
REQ-027 A stall counter SHALL count GRANTn cycles with s_waitrequest=1 and clear at each completion.
REQ-028 When the stall count reaches TIMEOUT, the arbiter SHALL enter ERR.
REQ-029 ERR SHALL last one cycle, with s_read=s_write=0, mn_waitrequest=0, mn_readdata=0 and mn_response=10 (SLVERR), then go to IDLE.
REQ-030 A granted master with read and write both high SHALL get ERR in the first grant cycle, with no slave strobe asserted.
REQ-031 A master that drops its request while granted (protocol violation) SHALL cause a return to IDLE without asserting any response.
REQ-032 The response output of a non-granted master SHALL be 00, and its readdata 0.

Reset
REQ-033 While reset_reset_n=0 at a clock edge, the block SHALL load: state IDLE, last-grant m1, both counters 0.
REQ-034 Reset SHALL take effect mid-transfer: slave strobes drop in the cycle after the reset edge, and no response is issued.
REQ-035 All outputs SHALL be in the IDLE values of REQ-013 and REQ-032 during reset.

Structure
REQ-036 The state enum and the response codes OKAY=00 and SLVERR=10 SHALL be defined in shared package avmm_arb_pkg.
REQ-037 The stall counter SHALL be sub-module avmm_arb_watchdog, with inputs clk_clk, reset_reset_n, enable, clear and output expired.
REQ-038 All arbitration, lock and mux logic SHALL remain in the top module.

Verification
REQ-039 Scenario: m0 reads addr 0x04, slave returns 0xDEADBEEF with 0 wait -> m0 completes on cycle 2 with readdata 0xDEADBEEF and response 00.
REQ-040 Scenario: m0 and m1 write simultaneously, 3 times back-to-back -> slave sees grants m0, m1, m0, m1, m0, m1.
REQ-041 Scenario: m0_lock=1 with 6 continuous m0 writes while m1 requests -> 4 m0 grants, then m1, then m0.
REQ-042 Scenario: m1 read with s_waitrequest held high -> after 255 stall cycles, m1 completes with response 10 and readdata 0, and the slave strobes are low in the ERR cycle.
REQ-043 Scenario: m0 asserts read and write together -> ERR one cycle after request, with s_read and s_write never high.
REQ-044 Scenario: reset asserted in the 3rd stall cycle of a granted m1 write -> s_write=0 in the following cycle, state IDLE, and the next tie is granted to m0.
